// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver.
// Synchronises the pad-side rx line, detects a start edge, samples each bit
// at its middle using a per-frame latched bit period, checks parity and stop
// bits, flags breaks, and hands finished words over with valid/ready.
module uart_rx_os #(
    parameter int unsigned MAX_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned PARITY_MODE   = 0,
    parameter int unsigned NUM_STOP_BITS = 1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [MAX_WIDTH-1:0]  clks_per_bit_i,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  break_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 3);
    localparam logic [MAX_WIDTH-1:0] N_MIN = MAX_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Line synchroniser and edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_q;
    logic                   fall;

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_q & ~rxs;

    // Shift the raw line through the synchroniser; idle-high reset keeps a
    // released reset from looking like a start edge.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, regardless of ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rxs_q  <= rxs;
        end
    end

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [MAX_WIDTH-1:0]    n_q, n_d;
    logic [MAX_WIDTH-1:0]    baud_q, baud_d;
    logic [BIT_CNT_W-1:0]    bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    serr_q, serr_d;
    logic                    stop0_q, stop0_d;

    logic [MAX_WIDTH-1:0]    n_in;
    logic                    tick;
    logic                    frame_done;
    logic                    new_perr;
    logic                    new_ferr;
    logic                    new_brk;
    logic                    first_stop_zero;

    // Bit periods below 4 cannot place a mid-bit sample sensibly.
    assign n_in = (clks_per_bit_i < N_MIN) ? N_MIN : clks_per_bit_i;

    // The baud counter equals (cycles since t0) mod N, so matching half the
    // period lands every sample in the middle of its bit.
    assign tick = (state_q != S_IDLE) && (baud_q == (n_q >> 1));

    // Frame-level state, counters and sample accumulators.
    // NOTE: the datapath registers are few and narrow, so they are reset
    // along with the control state; nothing here behaves like a memory.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            n_q     <= N_MIN;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            serr_q  <= 1'b0;
            stop0_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            serr_q  <= serr_d;
            stop0_q <= stop0_d;
        end
    end

    // Next-state logic: start detection, mid-bit sampling and bit counting.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        serr_d     = serr_q;
        stop0_d    = stop0_q;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    n_d     = n_in;
                    bit_d   = '0;
                    par_d   = 1'b0;
                    serr_d  = 1'b0;
                    stop0_d = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    // A high line at mid start bit was only a glitch.
                    state_d = rxs ? S_IDLE : S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rxs, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    par_d   = rxs;
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!rxs) begin
                        serr_d = 1'b1;
                    end
                    if (bit_q == '0) begin
                        stop0_d = ~rxs;
                    end
                    if (bit_q == BIT_CNT_W'(NUM_STOP_BITS - 1)) begin
                        state_d    = S_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Baud counter: parked at 0 in IDLE, starts from the edge cycle and wraps
    // at N-1 while a frame is in progress.
    always_comb begin
        baud_d = '0;
        if (state_q == S_IDLE) begin
            baud_d = fall ? MAX_WIDTH'(1) : '0;
        end else if (state_d == S_IDLE) begin
            baud_d = '0;
        end else if (baud_q == (n_q - MAX_WIDTH'(1))) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + MAX_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result evaluation (valid only in the final stop-sample cycle)
    // ------------------------------------------------------------------
    assign first_stop_zero = (bit_q == '0) ? ~rxs : stop0_q;
    assign new_ferr        = serr_q | ~rxs;

    // Parity and break flags for the frame being completed.
    always_comb begin
        new_perr = 1'b0;
        new_brk  = (shift_q == '0) && first_stop_zero;
        if (PARITY_MODE == 1) begin
            new_perr = (^shift_q) ^ par_q;
            new_brk  = new_brk && !par_q;
        end else if (PARITY_MODE == 2) begin
            new_perr = ~((^shift_q) ^ par_q);
            new_brk  = new_brk && !par_q;
        end
    end

    // ------------------------------------------------------------------
    // Output holding register and handshake
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  brk_q, brk_d;
    logic                  ovr_q, ovr_d;
    logic                  accept;

    assign accept = valid_q & rx_ready_i;

    // Commit a finished frame if the slot is free or being emptied this
    // cycle; otherwise drop it and flag the overrun.
    always_comb begin
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        valid_d = valid_q & ~accept;
        ovr_d   = 1'b0;
        if (frame_done) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                perr_d  = new_perr;
                ferr_d  = new_ferr;
                brk_d   = new_brk;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Output register bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign break_o      = brk_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: four receiver configurations on separate lines, a table of
// frames with expected words, a scoreboard queue, and hand-written sequences
// for timing, glitch, break, overrun and reset cases.
module tb_uart_rx_os;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg;
    logic [3:0]  rx_line;
    logic [3:0]  rdy;

    wire  [7:0]  d0, d1, d2;
    wire  [4:0]  d3;
    wire  [3:0]  v, pe, fe, bk, ov, bs;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: 8 bits even parity, 1: 8 bits odd parity, 2: 8 bits none, 3: 5 bits none 2 stop
    uart_rx_os #(.MAX_WIDTH(16), .DATA_WIDTH(8), .PARITY_MODE(1), .NUM_STOP_BITS(1), .SYNC_STAGES(SYNC)) u_even (
        .clk_i(clk), .rst_ni(rst_n), .clks_per_bit_i(cfg), .rx_i(rx_line[0]),
        .rx_data_o(d0), .rx_valid_o(v[0]), .rx_ready_i(rdy[0]), .parity_err_o(pe[0]),
        .frame_err_o(fe[0]), .break_o(bk[0]), .overrun_o(ov[0]), .busy_o(bs[0]));
    uart_rx_os #(.MAX_WIDTH(16), .DATA_WIDTH(8), .PARITY_MODE(2), .NUM_STOP_BITS(1), .SYNC_STAGES(SYNC)) u_odd (
        .clk_i(clk), .rst_ni(rst_n), .clks_per_bit_i(cfg), .rx_i(rx_line[1]),
        .rx_data_o(d1), .rx_valid_o(v[1]), .rx_ready_i(rdy[1]), .parity_err_o(pe[1]),
        .frame_err_o(fe[1]), .break_o(bk[1]), .overrun_o(ov[1]), .busy_o(bs[1]));
    uart_rx_os #(.MAX_WIDTH(16), .DATA_WIDTH(8), .PARITY_MODE(0), .NUM_STOP_BITS(1), .SYNC_STAGES(SYNC)) u_none (
        .clk_i(clk), .rst_ni(rst_n), .clks_per_bit_i(cfg), .rx_i(rx_line[2]),
        .rx_data_o(d2), .rx_valid_o(v[2]), .rx_ready_i(rdy[2]), .parity_err_o(pe[2]),
        .frame_err_o(fe[2]), .break_o(bk[2]), .overrun_o(ov[2]), .busy_o(bs[2]));
    uart_rx_os #(.MAX_WIDTH(16), .DATA_WIDTH(5), .PARITY_MODE(0), .NUM_STOP_BITS(2), .SYNC_STAGES(SYNC)) u_s2 (
        .clk_i(clk), .rst_ni(rst_n), .clks_per_bit_i(cfg), .rx_i(rx_line[3]),
        .rx_data_o(d3), .rx_valid_o(v[3]), .rx_ready_i(rdy[3]), .parity_err_o(pe[3]),
        .frame_err_o(fe[3]), .break_o(bk[3]), .overrun_o(ov[3]), .busy_o(bs[3]));

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    typedef struct {
        int         inst;
        int         n_cfg;
        int         n_bit;
        logic [8:0] data;
        logic       par;
        logic [1:0] stop;
        logic [8:0] e_data;
        logic       e_perr;
        logic       e_ferr;
        logic       e_brk;
    } vec_t;

    exp_t sb[$];
    int   valid_rise[4];
    int   valid_hi[4];
    int   ovr_cnt[4];
    int   rise_cyc[4];
    logic [3:0] v_prev = 4'b0;

    function automatic int dw(input int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic int pm(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 0);
    endfunction
    function automatic int ns(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic logic [8:0] get_data(input int i);
        case (i)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            2:       return {1'b0, d2};
            default: return {4'b0, d3};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one complete frame on line i, each bit held n_bit cycles.
    task automatic send_frame(input int i, input int n_bit, input logic [8:0] data,
                              input logic par, input logic [1:0] stop);
        logic [15:0] bits;
        int nb;
        bits = '1;
        nb = 0;
        bits[nb] = 1'b0;
        nb++;
        for (int k = 0; k < dw(i); k++) begin
            bits[nb] = data[k];
            nb++;
        end
        if (pm(i) != 0) begin
            bits[nb] = par;
            nb++;
        end
        for (int s = 0; s < ns(i); s++) begin
            bits[nb] = stop[s];
            nb++;
        end
        for (int b = 0; b < nb; b++) begin
            rx_line[i] = bits[b];
            step(n_bit);
        end
        rx_line[i] = 1'b1;
    endtask

    task automatic push(input int i, input logic [8:0] data, input logic perr,
                        input logic ferr, input logic brk);
        exp_t e;
        e.inst = i; e.data = data; e.perr = perr; e.ferr = ferr; e.brk = brk;
        sb.push_back(e);
    endtask

    // Monitor: counts valid activity and compares each accepted word with the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (v[i]) valid_hi[i]++;
            if (v[i] && !v_prev[i]) begin
                valid_rise[i]++;
                rise_cyc[i] = cyc;
            end
            if (ov[i]) ovr_cnt[i]++;
            if (v[i] && rdy[i]) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word inst %0d: got data %0h, expected no word", i, get_data(i));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_inst", i, e.inst);
                    check("sb_data", get_data(i), e.data);
                    check("sb_parity_err", pe[i], e.perr);
                    check("sb_frame_err", fe[i], e.ferr);
                    check("sb_break", bk[i], e.brk);
                end
            end
        end
        v_prev = v;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        int   c0;
        int   base;

        tbl[0]  = '{0, 16, 16, 9'h0A5, 1'b1, 2'b11, 9'h0A5, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1, 16, 16, 9'h0A5, 1'b1, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1, 16, 16, 9'h000, 1'b0, 2'b11, 9'h000, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{0, 16, 16, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{0, 16, 16, 9'h000, 1'b1, 2'b00, 9'h000, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{2, 16, 16, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{3, 5,  5,  9'h015, 1'b0, 2'b01, 9'h015, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{3, 5,  5,  9'h00A, 1'b0, 2'b10, 9'h00A, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{3, 2,  4,  9'h01F, 1'b0, 2'b11, 9'h01F, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{3, 0,  4,  9'h000, 1'b0, 2'b10, 9'h000, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{2, 7,  7,  9'h081, 1'b0, 2'b11, 9'h081, 1'b0, 1'b0, 1'b0};

        rst_n   = 1'b0;
        rx_line = 4'b1111;
        rdy     = 4'b1111;
        cfg     = 16'd16;
        for (int i = 0; i < 4; i++) begin
            valid_rise[i] = 0; valid_hi[i] = 0; ovr_cnt[i] = 0; rise_cyc[i] = 0;
        end
        step(5);
        @(negedge clk);
        check("reset_valid", v, 4'b0);
        check("reset_busy", bs, 4'b0);
        check("reset_flags", {pe, fe, bk, ov}, 16'b0);
        check("reset_data", {d0, d1, d2, d3}, 29'b0);
        step(1);
        rst_n = 1'b1;
        step(5);

        // Frame 0xA5 with good even parity; the period input changes mid-frame
        // and must not disturb the frame already in progress.
        push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        c0 = cyc;
        fork
            send_frame(0, 16, 9'h0A5, 1'b0, 2'b11);
            begin
                step(20);
                cfg = 16'd7;
            end
        join
        cfg = 16'd16;
        step(10);
        check("t1_valid_latency", rise_cyc[0] - c0, SYNC + 8 + 10 * 16 + 1);
        check("t1_valid_one_cycle", valid_hi[0], 1);
        check("t1_word_consumed", sb.size(), 0);

        // Table of frames across all four configurations.
        for (int r = 0; r < 11; r++) begin
            cfg = tbl[r].n_cfg[15:0];
            push(tbl[r].inst, tbl[r].e_data, tbl[r].e_perr, tbl[r].e_ferr, tbl[r].e_brk);
            send_frame(tbl[r].inst, tbl[r].n_bit, tbl[r].data, tbl[r].par, tbl[r].stop);
            step(2 * tbl[r].n_bit + 10);
            check($sformatf("row%0d_consumed", r), sb.size(), 0);
        end
        cfg = 16'd16;

        // Three-cycle glitch: start rejected, nothing committed.
        base = valid_rise[0];
        c0 = cyc;
        rx_line[0] = 1'b0;
        step(3);
        rx_line[0] = 1'b1;
        step(7);
        @(negedge clk);
        check("glitch_busy_at_sample", bs[0], 1'b1);
        step(1);
        @(negedge clk);
        check("glitch_busy_cleared", bs[0], 1'b0);
        check("glitch_cycle", cyc - c0, SYNC + 8 + 1);
        step(40);
        check("glitch_no_valid", valid_rise[0] - base, 0);

        // Line held low for 12 bit times: one break word, then silence until
        // the line returns high and falls again.
        base = valid_rise[2];
        push(2, 9'h000, 1'b0, 1'b1, 1'b1);
        rx_line[2] = 1'b0;
        step(12 * 16);
        check("break_one_word", valid_rise[2] - base, 1);
        check("break_busy_idle", bs[2], 1'b0);
        rx_line[2] = 1'b1;
        step(3 * 16);
        check("break_no_second", valid_rise[2] - base, 1);
        push(2, 9'h05A, 1'b0, 1'b0, 1'b0);
        send_frame(2, 16, 9'h05A, 1'b0, 2'b11);
        step(42);
        check("break_restart", valid_rise[2] - base, 2);
        check("break_queue", sb.size(), 0);

        // Back-to-back frames with the consumer stalled: second is dropped.
        rdy[2] = 1'b0;
        base = ovr_cnt[2];
        push(2, 9'h03C, 1'b0, 1'b0, 1'b0);
        send_frame(2, 16, 9'h03C, 1'b0, 2'b11);
        send_frame(2, 16, 9'h0C3, 1'b0, 2'b11);
        step(20);
        @(negedge clk);
        check("ovr_data_held", get_data(2), 9'h03C);
        check("ovr_valid_held", v[2], 1'b1);
        check("ovr_pulse_once", ovr_cnt[2] - base, 1);
        check("ovr_pending", sb.size(), 1);
        step(1);
        rdy[2] = 1'b1;
        @(negedge clk);
        check("ovr_valid_at_accept", v[2], 1'b1);
        step(1);
        @(negedge clk);
        check("ovr_valid_dropped", v[2], 1'b0);
        check("ovr_drained", sb.size(), 0);

        // Reset in the middle of the data bits: frame abandoned.
        step(1);
        cfg = 16'd5;
        base = valid_rise[3];
        rx_line[3] = 1'b0;
        step(5);
        rx_line[3] = 1'b1;
        step(5);
        @(negedge clk);
        check("rst_busy_before", bs[3], 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", bs, 4'b0);
        check("rst_valid", v, 4'b0);
        check("rst_flags", {pe, fe, bk, ov}, 16'b0);
        check("rst_data", {d0, d1, d2, d3}, 29'b0);
        step(3);
        rst_n = 1'b1;
        step(40);
        check("rst_no_commit", valid_rise[3] - base, 0);
        check("rst_idle_after", bs[3], 1'b0);
        check("final_queue_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Next-generation UART receiver with mid-bit sampling, derived from a per-bit clock count. It adds the following over the previous receiver:
- input synchroniser
- false-start rejection
- runtime-latched bit timing
- configurable data width, parity and stop bits
- parity, framing and break detection
- valid/ready output handshake with overrun reporting

It sits between the pad-side rx line and the UART register/FIFO layer.

Parameters:
MAX_WIDTH, 16, width of clks_per_bit_i
DATA_WIDTH, 8, data bits per frame; legal 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
NUM_STOP_BITS, 1, stop bits checked; legal 1 or 2
SYNC_STAGES, 2, flops in rx_i synchroniser; legal >= 2

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
clks_per_bit_i  input  MAX_WIDTH  clock cycles per bit (N); values < 4 are treated as 4
rx_i  input  1  asynchronous serial line, idle high
rx_data_o  output  DATA_WIDTH  received data, LSB first on the line
rx_valid_o  output  1  rx_data_o and the error flags are valid
rx_ready_i  input  1  consumer accepts the word when rx_valid_o && rx_ready_i
parity_err_o  output  1  parity mismatch for the held word; always 0 when PARITY_MODE = 0
frame_err_o  output  1  any stop bit sampled 0 for the held word
break_o  output  1  held word is a break: all data bits, parity (if present) and first stop bit are 0
overrun_o  output  1  one-cycle pulse when a completed frame is dropped
busy_o  output  1  state != IDLE

Behaviour:
- Reset: synchroniser flops = 1, state = IDLE, all outputs 0, rx_data_o = 0.
- rxs is the synchronised rx_i, delayed SYNC_STAGES cycles. rxs_q is its one-cycle delayed copy.
- States: IDLE, START, DATA, PARITY (only if PARITY_MODE != 0), STOP.
- IDLE -> START on a falling edge (rxs_q = 1, rxs = 0) at cycle t0.
  - N is latched from clks_per_bit_i at t0; later changes take effect only on the next frame.
  - Bit counter is cleared at t0.
- START: sample rxs at t0 + floor(N/2).
  - Sample = 1: false start, return to IDLE, no output, no flags.
  - Sample = 0: go to DATA.
- All subsequent samples occur every N cycles: sample k (k = 1..) at t0 + floor(N/2) + k*N.
- DATA: DATA_WIDTH samples, shifted LSB first; then go to PARITY, or to STOP if PARITY_MODE = 0.
- PARITY: one sample p.
  - Even mode: error if XOR(data, p) = 1.
  - Odd mode: error if XOR(data, p) = 0.
- STOP: NUM_STOP_BITS samples. frame_err is set if any stop sample = 0.
  - At the final stop sample, return to IDLE in the same cycle and present the result on the next cycle.
- IDLE requires a new falling edge to start a frame. A line held low after a framing error or break does not restart reception until it has returned high.
- Result commit (cycle after final stop sample):
  - If rx_valid_o = 0, or rx_valid_o && rx_ready_i in the commit cycle: load rx_data_o and all three flags, and set rx_valid_o = 1.
  - Otherwise keep the old word and flags, drop the new frame, and pulse overrun_o for 1 cycle.
- Handshake:
  - rx_valid_o falls on the cycle after rx_valid_o && rx_ready_i, unless a commit occurs in that same cycle.
  - rx_data_o and the flags stay stable while rx_valid_o = 1 and rx_ready_i = 0.
- Counters:
  - Baud counter is MAX_WIDTH bits, counts 0..N-1 and wraps; it never free-runs in IDLE (held at 0).
  - Bit counter is sized $clog2(DATA_WIDTH + 3).
- Asynchronous reset mid-frame: the frame is abandoned, all state returns to reset values, and nothing is committed.

Test Plan:
1. Frame 0xA5 (N = 16, DATA_WIDTH = 8, PARITY_MODE = 1, parity bit 0, 1 stop, rx_ready_i = 1) -> rx_data_o = 0xA5, no error flags, rx_valid_o high for 1 cycle at t0 + 8 + 10*16 + 1.
2. Same setup, parity bit sent as 1 -> rx_data_o = 0xA5, parity_err_o = 1. Then set PARITY_MODE = 2 and send 0xA5 with parity 1 -> no error.
3. 3-cycle low glitch on rx_i (N = 16) -> false start: no rx_valid_o, busy_o back to 0 within 8 + SYNC_STAGES + 1 cycles.
4. Line held low for 12 bit times (PARITY_MODE = 0) -> rx_data_o = 0x00 with frame_err_o = 1 and break_o = 1. No second frame until the line has gone high then low again.
5. Two back-to-back frames 0x3C then 0xC3 with rx_ready_i = 0 -> rx_data_o stays 0x3C and overrun_o pulses once. Raise rx_ready_i -> rx_valid_o drops the next cycle.
6. NUM_STOP_BITS = 2, DATA_WIDTH = 5, N = 5: frame 0x15 with second stop bit 0 -> frame_err_o = 1, break_o = 0. Also assert rst_ni mid-data -> no valid output, all outputs return to 0.
